// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared definitions for the Z80-style bus initiator.
//   - FSM state encoding (9 states, 4-bit)
//   - cycle-type codes for the latched request
//   - data returned on an aborted or timed-out cycle
//   - small decode helpers used by the master
package z80_bus_pkg;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_ARB  = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_TWA  = 4'd4;
  localparam logic [3:0] ST_TW   = 4'd5;
  localparam logic [3:0] ST_T3   = 4'd6;
  localparam logic [3:0] ST_HOLD = 4'd7;
  localparam logic [3:0] ST_REL  = 4'd8;

  localparam logic [1:0] CYC_MEM_RD = 2'b00;
  localparam logic [1:0] CYC_MEM_WR = 2'b01;
  localparam logic [1:0] CYC_IO_RD  = 2'b10;
  localparam logic [1:0] CYC_IO_WR  = 2'b11;

  localparam logic [7:0] RD_ABORT_DATA = 8'hFF;

  localparam int HOLD_CNT_W = 8;

  typedef struct packed {
    logic [1:0]  cyc;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_req_t;

  function automatic logic cyc_is_io(input logic [1:0] cyc);
    return (cyc == CYC_IO_RD) || (cyc == CYC_IO_WR);
  endfunction

  function automatic logic cyc_is_write(input logic [1:0] cyc);
    return (cyc == CYC_MEM_WR) || (cyc == CYC_IO_WR);
  endfunction

  // Bus is owned from T1 through HOLD (busack seen, busreq still low).
  function automatic logic st_owned(input logic [3:0] st);
    return st inside {ST_T1, ST_T2, ST_TWA, ST_TW, ST_T3, ST_HOLD};
  endfunction

  // A bus cycle is in flight; an abort here must produce a response.
  function automatic logic st_in_cycle(input logic [3:0] st);
    return st inside {ST_T1, ST_T2, ST_TWA, ST_TW, ST_T3};
  endfunction

  // Command strobes (MREQ/IORQ + RD/WR) are asserted in these states.
  function automatic logic st_strobe(input logic [3:0] st);
    return st inside {ST_T2, ST_TWA, ST_TW, ST_T3};
  endfunction

endpackage

// File: rtl/z80_bus_hold_timer.sv
// z80_bus_hold_timer: loadable down-counter timing the bus-hold window.
// Ports:
//   clk_cpu   in   CPU clock, posedge
//   reset_cpu in   synchronous active-low reset
//   load      in   load load_val (takes priority over en)
//   load_val  in   W-bit reload value
//   en        in   decrement while nonzero
//   expire    out  counter is at zero
module z80_bus_hold_timer
  import z80_bus_pkg::*;
#(
  parameter int W = HOLD_CNT_W
) (
  input  logic         clk_cpu,
  input  logic         reset_cpu,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (!reset_cpu) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/z80_bus_master.sv
// z80_bus_master: Z80-style bus initiator. Arbitrates with BUSREQ/BUSACK,
// runs single memory/IO read/write cycles (T1/T2/TWA/TW/T3) for a simple
// request/response client, holds the bus for back-to-back requests and
// releases it after HOLD_CYCLES idle cycles.
//
// Optional feature: define Z80_BUS_MASTER_WAIT_TIMEOUT_EN to bound TW states
// at WAIT_TIMEOUT per cycle (response then carries rsp_err, rdata 8'hFF).
// Without the macro the WAIT_TIMEOUT parameter and its counter do not exist.
//
// Ports:
//   clk_cpu, reset_cpu           clock, synchronous active-low reset
//   req_valid/ready/write/io     client request handshake and cycle type
//   req_addr, req_wdata          cycle address, write data
//   rsp_valid, rsp_rdata, rsp_err  one-cycle response
//   busreq_n, busack_n           bus arbitration
//   wait_n                       bus wait input
//   bus_oe, a_out                address/strobe pad enable, address
//   d_out, d_oe, d_in            data bus
//   mreq_n, iorq_n, rd_n, wr_n   command strobes
//
// state | meaning
// IDLE  | bus not owned, waiting for a request
// ARB   | busreq_n low, waiting for busack_n
// T1    | address driven, strobes high
// T2    | strobes asserted
// TWA   | automatic IO wait state
// TW    | wait_n-requested wait state
// T3    | last strobe cycle, data sampled at exit
// HOLD  | bus kept owned, accepts back-to-back requests
// REL   | bus released, returning to IDLE
module z80_bus_master
  import z80_bus_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
`ifdef Z80_BUS_MASTER_WAIT_TIMEOUT_EN
  ,
  parameter int WAIT_TIMEOUT = 255
`endif
) (
  input  logic        clk_cpu,
  input  logic        reset_cpu,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busreq_n,
  input  logic        busack_n,
  input  logic        wait_n,
  output logic        bus_oe,
  output logic [15:0] a_out,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        mreq_n,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD =
    HOLD_CNT_W'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);

  logic [3:0] state_q, state_d;
  bus_req_t   req_q, req_d;

  logic busreq_n_q, busreq_n_d;
  logic bus_oe_q, bus_oe_d;
  logic mreq_n_q, mreq_n_d;
  logic iorq_n_q, iorq_n_d;
  logic rd_n_q, rd_n_d;
  logic wr_n_q, wr_n_d;
  logic d_oe_q, d_oe_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_err_q, rsp_err_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;

  logic accept, abort, strobe;
  logic hold_load, hold_expire;
  logic wait_tmo, done_err;

  // busack loss in HOLD must not swallow a request, so ready drops with it.
  assign req_ready = (state_q == ST_IDLE) ||
                     ((state_q == ST_HOLD) && (HOLD_CYCLES != 0) && !busack_n);
  assign accept    = req_valid && req_ready;
  assign abort     = st_owned(state_q) && busack_n;

`ifdef Z80_BUS_MASTER_WAIT_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_TIMEOUT);

  // wait_cnt_q holds the ordinal of the current TW state (1 = first).
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  assign wait_tmo = !wait_n && (wait_cnt_q >= WAIT_LIMIT);
  assign done_err = timeout_q;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (state_d == ST_T1) begin
      timeout_d = 1'b0;
    end
    if (state_d == ST_TW) begin
      wait_cnt_d = (state_q == ST_TW) ? wait_cnt_q + 8'd1 : 8'd1;
    end
    if ((state_q == ST_TW) && (state_d == ST_T3) && wait_tmo) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (!reset_cpu) begin
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
`else
  assign wait_tmo = 1'b0;
  assign done_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    if (accept) begin
      req_d.cyc   = req_io ? (req_write ? CYC_IO_WR  : CYC_IO_RD)
                           : (req_write ? CYC_MEM_WR : CYC_MEM_RD);
      req_d.addr  = req_addr;
      req_d.wdata = req_wdata;
    end
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_ARB;
      ST_ARB:  if (!busack_n) state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2: begin
        if (cyc_is_io(req_q.cyc)) state_d = ST_TWA;
        else                      state_d = wait_n ? ST_T3 : ST_TW;
      end
      ST_TWA:  state_d = wait_n ? ST_T3 : ST_TW;
      ST_TW:   if (wait_n || wait_tmo) state_d = ST_T3;
      ST_T3:   state_d = ST_HOLD;
      ST_HOLD: begin
        if (accept)           state_d = ST_T1;
        else if (hold_expire) state_d = ST_REL;
      end
      ST_REL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  assign hold_load = (state_q == ST_T3) && (state_d == ST_HOLD);

  z80_bus_hold_timer #(.W(HOLD_CNT_W)) u_hold_timer (
    .clk_cpu   (clk_cpu),
    .reset_cpu (reset_cpu),
    .load      (hold_load),
    .load_val  (HOLD_LOAD),
    .en        (state_q == ST_HOLD),
    .expire    (hold_expire)
  );

  // Pin values are registered from the next state so the pads see clean,
  // edge-aligned strobes.
  always_comb begin
    strobe      = st_strobe(state_d);
    busreq_n_d  = !((state_d == ST_ARB) || st_owned(state_d));
    bus_oe_d    = st_owned(state_d);
    mreq_n_d    = !(strobe && !cyc_is_io(req_d.cyc));
    iorq_n_d    = !(strobe && cyc_is_io(req_d.cyc));
    rd_n_d      = !(strobe && !cyc_is_write(req_d.cyc));
    wr_n_d      = !(strobe && cyc_is_write(req_d.cyc));
    d_oe_d      = st_in_cycle(state_d) && cyc_is_write(req_d.cyc);

    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    if (abort) begin
      if (st_in_cycle(state_q)) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = RD_ABORT_DATA;
      end
    end else if (state_q == ST_T3) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = done_err;
      if (done_err)                     rsp_rdata_d = RD_ABORT_DATA;
      else if (cyc_is_write(req_q.cyc)) rsp_rdata_d = 8'h00;
      else                              rsp_rdata_d = d_in;
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (!reset_cpu) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      busreq_n_q  <= 1'b1;
      bus_oe_q    <= 1'b0;
      mreq_n_q    <= 1'b1;
      iorq_n_q    <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      d_oe_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      busreq_n_q  <= busreq_n_d;
      bus_oe_q    <= bus_oe_d;
      mreq_n_q    <= mreq_n_d;
      iorq_n_q    <= iorq_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      d_oe_q      <= d_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign busreq_n  = busreq_n_q;
  assign bus_oe    = bus_oe_q;
  assign mreq_n    = mreq_n_q;
  assign iorq_n    = iorq_n_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;
  assign d_oe      = d_oe_q;
  assign a_out     = req_q.addr;
  assign d_out     = req_q.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_z80_bus_master.sv
// Bench for z80_bus_master. The bench plays client, bus arbiter and target.
// Expected pin behaviour comes from a per-transaction timeline: arbitration
// cycles, one T1, (2 + io + waits) strobe cycles, one response cycle, then a
// HOLD window of HOLD_N cycles counted from the response cycle.
module tb_z80_bus_master;

  localparam int HOLD_N = 4;
  localparam int IDLE_OFS = 1000;

  logic        clk_cpu = 1'b0;
  logic        reset_cpu;
  logic        req_valid, req_ready, req_write, req_io;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        busreq_n, busack_n, wait_n, bus_oe, d_oe;
  logic [15:0] a_out;
  logic [7:0]  d_out, d_in;
  logic        mreq_n, iorq_n, rd_n, wr_n;

  int n_vec = 0;
  int n_err = 0;
  int hold_ofs = IDLE_OFS;   // cycles since last response; >= HOLD_N means released

  always #5 clk_cpu = ~clk_cpu;

  z80_bus_master #(
    .HOLD_CYCLES(HOLD_N)
`ifdef Z80_BUS_MASTER_WAIT_TIMEOUT_EN
    , .WAIT_TIMEOUT(5)
`endif
  ) dut (
    .clk_cpu(clk_cpu), .reset_cpu(reset_cpu),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busreq_n(busreq_n), .busack_n(busack_n), .wait_n(wait_n),
    .bus_oe(bus_oe), .a_out(a_out), .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {bus_oe, busreq_n, mreq_n, iorq_n, rd_n, wr_n, d_oe}
  task automatic chk_pins(input string tag, input bit oe, input bit brq, input bit mq,
                          input bit iq, input bit rdn, input bit wrn, input bit doe);
    chk(tag, {9'd0, bus_oe, busreq_n, mreq_n, iorq_n, rd_n, wr_n, d_oe},
             {9'd0, oe, brq, mq, iq, rdn, wrn, doe});
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk_cpu);
      if (hold_ofs < IDLE_OFS) hold_ofs++;
      chk_pins("idle_pins", hold_ofs < HOLD_N, !(hold_ofs < HOLD_N), 1, 1, 1, 1, 0);
      chk("idle_ready", req_ready, hold_ofs != HOLD_N);
      chk("idle_rsp", rsp_valid, 0);
      if (hold_ofs == HOLD_N) busack_n = 1'b1;
    end
  endtask

  // Called at a negedge; returns at the negedge of the response cycle (or
  // the cycle after an abort/reset injected at strobe index kill_at).
  task automatic run_txn(input bit wr, input bit io, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] rd,
                         input int nwait, input int arb, input bit tmo,
                         input int kill_at, input bit kill_rst);
    bit held;
    int len;
    logic [7:0] exp_rd;
    if (hold_ofs == HOLD_N) idle(1);
    held = (hold_ofs < HOLD_N);
    len = 2 + int'(io) + nwait;
    chk("req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_io = io; req_addr = addr; req_wdata = wd;
    if (!held) begin
      for (int i = 0; i <= arb; i++) begin
        @(negedge clk_cpu);
        req_valid = 1'b0;
        chk_pins("arb_pins", 0, 0, 1, 1, 1, 1, 0);
        chk("arb_ready", req_ready, 0);
        if (i == arb) busack_n = 1'b0;
      end
    end
    @(negedge clk_cpu);
    req_valid = 1'b0;
    chk_pins("t1_pins", 1, 0, 1, 1, 1, 1, wr);
    chk("t1_addr", a_out, addr);
    if (wr) chk("t1_dout", d_out, wd);
    chk("t1_ready", req_ready, 0);
    d_in = ~rd;
    for (int i = 0; i < len; i++) begin
      @(negedge clk_cpu);
      chk_pins("strobe_pins", 1, 0, io, !io, wr, !wr, wr);
      chk("strobe_addr", a_out, addr);
      chk("strobe_rsp", rsp_valid, 0);
      wait_n = tmo ? 1'b0 : !(i >= int'(io) && i < int'(io) + nwait);
      d_in = (i == len - 1) ? rd : ~rd;
      if (i == kill_at) begin
        if (kill_rst) reset_cpu = 1'b0;
        else          busack_n = 1'b1;
        @(negedge clk_cpu);
        reset_cpu = 1'b1;
        wait_n = 1'b1;
        busack_n = 1'b1;
        chk_pins("kill_pins", 0, 1, 1, 1, 1, 1, 0);
        chk("kill_rsp_valid", rsp_valid, !kill_rst);
        chk("kill_rsp_err", rsp_err, !kill_rst);
        chk("kill_rdata", rsp_rdata, kill_rst ? 8'h00 : 8'hFF);
        if (kill_rst) chk("kill_aout", a_out, 16'h0000);
        hold_ofs = IDLE_OFS;
        return;
      end
    end
    @(negedge clk_cpu);
    wait_n = 1'b1;
    exp_rd = tmo ? 8'hFF : (wr ? 8'h00 : rd);
    chk_pins("rsp_pins", 1, 0, 1, 1, 1, 1, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, tmo);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_ready", req_ready, 1);
    hold_ofs = 0;
  endtask

  initial begin
    reset_cpu = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
    req_addr = 16'h0; req_wdata = 8'h0; busack_n = 1'b1; wait_n = 1'b1; d_in = 8'h0;
    repeat (3) @(negedge clk_cpu);
    chk_pins("reset_pins", 0, 1, 1, 1, 1, 1, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rdata", rsp_rdata, 8'h00);
    chk("reset_aout", a_out, 16'h0000);
    chk("reset_dout", d_out, 8'h00);
    reset_cpu = 1'b1;

    // memory read, arbitration delay, then release after the hold window
    run_txn(0, 0, 16'h1234, 8'h00, 8'h5A, 0, 2, 0, -1, 0);
    idle(HOLD_N + 2);
    // IO write: T2, TWA, T3 strobes, d_oe through T3
    run_txn(1, 1, 16'h0080, 8'hC3, 8'h77, 0, 1, 0, -1, 0);
    // back-to-back memory read with three waits, issued in the rsp cycle
    run_txn(0, 0, 16'hBEEF, 8'h00, 8'hA5, 3, 0, 0, -1, 0);
    run_txn(1, 0, 16'h0001, 8'h3C, 8'h00, 0, 0, 0, -1, 0);

    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = int'($urandom_range(0, 6));
      if (gap > 0) idle(gap);
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
              8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 0, -1, 0);
    end

    // busack_n lost during the second TW state
    idle(2);
    run_txn(0, 0, 16'h4321, 8'h00, 8'h11, 3, 0, 0, 2, 0);
    // reset asserted during T2
    run_txn(1, 0, 16'h2222, 8'h33, 8'h00, 0, 0, 0, 0, 1);
    run_txn(0, 1, 16'h00F0, 8'h00, 8'h96, 1, 1, 0, -1, 0);
`ifdef Z80_BUS_MASTER_WAIT_TIMEOUT_EN
    idle(1);
    run_txn(0, 0, 16'h5555, 8'h00, 8'h66, 5, 0, 1, -1, 0);
`endif
    idle(HOLD_N + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
